// File: rtl/vga_pattern_gen.sv
// VGA timing generator with a built-in test-pattern engine (chessboard, colour bars,
// solid colour, scrolling chessboard). All outputs are registered, one pixel clock domain.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int SQ_LOG2  = 6,
  localparam int RGB_W   = R_W + G_W + B_W,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] fg_color,
  input  logic [RGB_W-1:0] bg_color,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic             frame_start,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y
);

  logic             r_run;
  logic [X_W-1:0]   r_h;
  logic [Y_W-1:0]   r_v;
  logic [SQ_LOG2:0] r_off;
  logic [1:0]       r_mode;
  logic [RGB_W-1:0] r_fg;
  logic [RGB_W-1:0] r_bg;

  logic             w_frame_end;
  logic [31:0]      w_h32;
  logic [31:0]      w_v32;
  logic             w_active;
  logic             w_hs_on;
  logic             w_vs_on;
  logic [2:0]       w_bar;
  logic [2:0]       w_c;
  logic [SQ_LOG2:0] w_xs;
  logic             w_sq;
  logic [RGB_W-1:0] w_pix;

  assign w_frame_end = r_run && (r_h == X_W'(H_TOTAL - 1)) && (r_v == Y_W'(V_TOTAL - 1));

  // Counters, frame-boundary latching of mode/colours and the scroll offset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_h    <= '0;
      r_v    <= '0;
      r_off  <= '0;
      r_mode <= 2'd0;
      r_fg   <= fg_color;
      r_bg   <= bg_color;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (r_h == X_W'(H_TOTAL - 1)) begin
          r_h <= '0;
          r_v <= (r_v == Y_W'(V_TOTAL - 1)) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
      if (w_frame_end) begin
        if (r_mode == 2'd3) r_off <= r_off + 1'b1;
        r_mode <= mode;
        r_fg   <= fg_color;
        r_bg   <= bg_color;
      end
    end
  end

  // Pixel generation from the current counter position
  always_comb begin
    w_h32    = 32'(r_h);
    w_v32    = 32'(r_v);
    w_active = (w_h32 < 32'(H_ACTIVE)) && (w_v32 < 32'(V_ACTIVE));
    w_hs_on  = (w_h32 >= 32'(H_ACTIVE + H_FP)) && (w_h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
    w_vs_on  = (w_v32 >= 32'(V_ACTIVE + V_FP)) && (w_v32 < 32'(V_ACTIVE + V_FP + V_SYNC));

    // Bar index by constant threshold compares; leftover pixels stay in bar 7
    w_bar = 3'd0;
    for (int m = 1; m < 8; m++) begin
      if (w_h32 >= 32'(m * (H_ACTIVE / 8))) w_bar = 3'(m);
    end
    w_c = 3'd7 - w_bar;

    w_xs = r_h[SQ_LOG2:0] + ((r_mode == 2'd3) ? r_off : '0);
    w_sq = w_xs[SQ_LOG2] ^ r_v[SQ_LOG2];

    case (r_mode)
      2'd1:    w_pix = {{R_W{w_c[2]}}, {G_W{w_c[1]}}, {B_W{w_c[0]}}};
      2'd2:    w_pix = r_fg;
      default: w_pix = w_sq ? r_fg : r_bg;
    endcase
  end

  // Output register stage; held at idle values during reset and the restart cycle
  always_ff @(posedge clk) begin
    if (rst || !r_run) begin
      vga_rgb     <= '0;
      vga_de      <= 1'b0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      vga_rgb     <= w_active ? w_pix : '0;
      vga_de      <= w_active;
      vga_hs      <= w_hs_on ? HS_POL : ~HS_POL;
      vga_vs      <= w_vs_on ? VS_POL : ~VS_POL;
      frame_start <= (r_h == '0) && (r_v == '0);
      pix_x       <= r_h;
      pix_y       <= r_v;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen: a reduced-size raster driven with random mode/colour
// changes and reset pulses, every output checked each clock against a frame-arithmetic model.
module tb_vga_pattern_gen;

  localparam int HA = 68, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam bit HSP = 1'b0, VSP = 1'b1;
  localparam int RW = 3, GW = 3, BW = 2, SQL = 2;
  localparam int XW = $clog2(HT), YW = $clog2(VT);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [7:0]    fg_color, bg_color;
  logic [7:0]    vga_rgb;
  logic          vga_hs, vga_vs, vga_de, frame_start;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .R_W(RW), .G_W(GW), .B_W(BW), .SQ_LOG2(SQL)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .fg_color(fg_color), .bg_color(bg_color),
    .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Model state: clocks since reset release plus the per-frame latched settings
  int         k;
  int         m_mode;
  logic [7:0] m_fg, m_bg;
  int         m_off;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  function automatic logic [7:0] ref_pix(input int md, input int h, input int v,
                                         input logic [7:0] f, input logic [7:0] b, input int off);
    int bar, c, xs;
    logic [7:0] px;
    case (md)
      1: begin
        bar = h / (HA / 8);
        if (bar > 7) bar = 7;
        c  = 7 - bar;
        px = 8'(((c >> 2) & 1) * (((1 << RW) - 1) << (GW + BW)))
           | 8'(((c >> 1) & 1) * (((1 << GW) - 1) << BW))
           | 8'((c & 1) * ((1 << BW) - 1));
      end
      2: px = f;
      3: begin
        xs = (h + off) % (2 << SQL);
        px = ((((xs >> SQL) ^ (v >> SQL)) & 1) != 0) ? f : b;
      end
      default: px = ((((h >> SQL) ^ (v >> SQL)) & 1) != 0) ? f : b;
    endcase
    return px;
  endfunction

  task automatic step();
    int p, h, v;
    logic [7:0] e_rgb;
    logic e_de, e_hs, e_vs, e_fs;
    int e_x, e_y;
    @(posedge clk);
    if (rst) begin
      k = 0; m_mode = 0; m_fg = fg_color; m_bg = bg_color; m_off = 0;
    end else begin
      k++;
    end
    if (k >= 2) begin
      p    = k - 2;
      h    = p % HT;
      v    = (p / HT) % VT;
      e_de = (h < HA) && (v < VA);
      e_hs = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : ~HSP;
      e_vs = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : ~VSP;
      e_fs = (p % FT) == 0;
      e_x  = h;
      e_y  = v;
      e_rgb = e_de ? ref_pix(m_mode, h, v, m_fg, m_bg, m_off) : 8'h00;
      if (h == HT - 1 && v == VT - 1) begin
        if (m_mode == 3) m_off = (m_off + 1) % (2 << SQL);
        m_mode = int'(mode); m_fg = fg_color; m_bg = bg_color;
      end
    end else begin
      e_rgb = 8'h00; e_de = 1'b0; e_hs = ~HSP; e_vs = ~VSP; e_fs = 1'b0; e_x = 0; e_y = 0;
    end
    #1;
    check("rgb", 32'(vga_rgb), 32'(e_rgb));
    check("de", 32'(vga_de), 32'(e_de));
    check("hs", 32'(vga_hs), 32'(e_hs));
    check("vs", 32'(vga_vs), 32'(e_vs));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("pix_x", 32'(pix_x), 32'(e_x));
    check("pix_y", 32'(pix_y), 32'(e_y));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; fg_color = 8'hFF; bg_color = 8'h00;
    k = 0; m_mode = 0; m_fg = 8'hFF; m_bg = 8'h00; m_off = 0;
    run(3);
    rst = 1'b0;
    run(FT + 500);
    mode = 2'd1;
    run(FT);
    mode = 2'd0;
    run(FT / 2);
    mode = 2'd2; fg_color = 8'($urandom);
    run(FT + FT / 2);
    mode = 2'd3; fg_color = 8'($urandom); bg_color = 8'($urandom);
    run(9 * FT + $urandom_range(0, 200));
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(FT + 300);
    for (int j = 0; j < 20; j++) begin
      mode     = 2'($urandom_range(0, 3));
      fg_color = 8'($urandom);
      bg_color = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 3));
        rst = 1'b0;
      end
      run($urandom_range(50, 1500));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
